// File: rtl/rv_mc_ctrl_hs_if.sv
// Control bus between the multicycle controller and its datapath and memory.
// master is the controller side; slave is the datapath/memory side.
interface rv_mc_ctrl_hs_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             zero;
    logic             lt;
    logic             ltu;
    logic             mem_ready;
    logic             mem_req;
    logic [1:0]       sel_alu_src_a;
    logic [1:0]       sel_alu_src_b;
    logic [1:0]       sel_result;
    logic             sel_mem_addr;
    logic [2:0]       sel_ext;
    logic [3:0]       alu_control;
    logic             we_mem;
    logic             we_pc;
    logic             we_ir;
    logic             we_rf;
    logic             bus_err;
    logic             trap;
    logic [CNT_W-1:0] instret;

    modport master (
        input  op, funct3, funct7b5, zero, lt, ltu, mem_ready,
        output mem_req, sel_alu_src_a, sel_alu_src_b, sel_result, sel_mem_addr,
               sel_ext, alu_control, we_mem, we_pc, we_ir, we_rf,
               bus_err, trap, instret
    );

    modport slave (
        output op, funct3, funct7b5, zero, lt, ltu, mem_ready,
        input  mem_req, sel_alu_src_a, sel_alu_src_b, sel_result, sel_mem_addr,
               sel_ext, alu_control, we_mem, we_pc, we_ir, we_rf,
               bus_err, trap, instret
    );
endinterface

// File: rtl/rv_mc_ctrl_hs.sv
// Multicycle RV32I controller with req/ready memory handshake, wait watchdog and instret.
// Define RV_MC_ILLEGAL_TRAP_EN to trap unknown opcodes; otherwise they retire as NOPs.
module rv_mc_ctrl_hs #(
    parameter int MEM_TIMEOUT = 0,
    parameter int TMO_W       = 8,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    rv_mc_ctrl_hs_if.master      bus
);
    typedef enum logic [4:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB,
        BRANCH, JAL, JALR, JALR2, LUI, AUIPC, ILLEGAL, ERROR
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_S = 3'b001;
    localparam logic [2:0] EXT_B = 3'b010;
    localparam logic [2:0] EXT_J = 3'b011;
    localparam logic [2:0] EXT_U = 3'b100;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

    state_t           state, state_n;
    logic [TMO_W-1:0] wait_cnt;
    logic [CNT_W-1:0] instret_q;
    logic             bus_err_q;
    logic             timeout;

    // Immediate forms never subtract; funct7b5 only picks arithmetic right shift there.
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7b5,
                                           input logic is_reg);
        case (f3)
            3'b000:  alu_dec = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

    function automatic logic br_cond(input logic [2:0] f3, input logic z,
                                     input logic l, input logic lu);
        case (f3)
            3'b000:  br_cond = z;
            3'b001:  br_cond = !z;
            3'b100:  br_cond = l;
            3'b101:  br_cond = !l;
            3'b110:  br_cond = lu;
            3'b111:  br_cond = !lu;
            default: br_cond = 1'b0;
        endcase
    endfunction

    assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == TMO_LIM) && !bus.mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n           = state;
        bus.mem_req       = 1'b0;
        bus.sel_alu_src_a = 2'b00;
        bus.sel_alu_src_b = 2'b00;
        bus.sel_result    = 2'b00;
        bus.sel_mem_addr  = 1'b0;
        bus.sel_ext       = EXT_I;
        bus.alu_control   = ALU_ADD;
        bus.we_mem        = 1'b0;
        bus.we_pc         = 1'b0;
        bus.we_ir         = 1'b0;
        bus.we_rf         = 1'b0;
        case (state)
            FETCH: begin
                bus.mem_req       = 1'b1;
                bus.sel_alu_src_b = 2'b10;
                bus.sel_result    = 2'b10;
                if (timeout) begin
                    state_n = ERROR;
                end else if (bus.mem_ready) begin
                    bus.we_ir = 1'b1;
                    bus.we_pc = 1'b1;
                    state_n   = DECODE;
                end
            end
            DECODE: begin
                bus.sel_alu_src_a = 2'b01;
                bus.sel_alu_src_b = 2'b01;
                bus.sel_ext       = (bus.op == OP_JAL) ? EXT_J : EXT_B;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_n = MEMADR;
                    OP_R:              state_n = EXECR;
                    OP_I:              state_n = EXECI;
                    OP_BR:             state_n = BRANCH;
                    OP_JAL:            state_n = JAL;
                    OP_JALR:           state_n = JALR;
                    OP_LUI:            state_n = LUI;
                    OP_AUIPC:          state_n = AUIPC;
                    default:           state_n = ILLEGAL;
                endcase
            end
            MEMADR: begin
                bus.sel_alu_src_a = 2'b10;
                bus.sel_alu_src_b = 2'b01;
                bus.sel_ext       = (bus.op == OP_STORE) ? EXT_S : EXT_I;
                state_n           = (bus.op == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                bus.mem_req      = 1'b1;
                bus.sel_mem_addr = 1'b1;
                if (timeout)             state_n = ERROR;
                else if (bus.mem_ready)  state_n = MEMWB;
            end
            MEMWB: begin
                bus.sel_result = 2'b01;
                bus.we_rf      = 1'b1;
                state_n        = FETCH;
            end
            MEMWRITE: begin
                bus.mem_req      = 1'b1;
                bus.we_mem       = 1'b1;
                bus.sel_mem_addr = 1'b1;
                if (timeout)             state_n = ERROR;
                else if (bus.mem_ready)  state_n = FETCH;
            end
            EXECR: begin
                bus.sel_alu_src_a = 2'b10;
                bus.alu_control   = alu_dec(bus.funct3, bus.funct7b5, 1'b1);
                state_n           = ALUWB;
            end
            EXECI: begin
                bus.sel_alu_src_a = 2'b10;
                bus.sel_alu_src_b = 2'b01;
                bus.alu_control   = alu_dec(bus.funct3, bus.funct7b5, 1'b0);
                state_n           = ALUWB;
            end
            ALUWB: begin
                bus.we_rf = 1'b1;
                state_n   = FETCH;
            end
            BRANCH: begin
                bus.sel_alu_src_a = 2'b10;
                bus.alu_control   = ALU_SUB;
                bus.we_pc         = br_cond(bus.funct3, bus.zero, bus.lt, bus.ltu);
                state_n           = FETCH;
            end
            JAL, JALR2: begin
                bus.sel_alu_src_a = 2'b01;
                bus.sel_alu_src_b = 2'b10;
                bus.we_pc         = 1'b1;
                state_n           = ALUWB;
            end
            JALR: begin
                bus.sel_alu_src_a = 2'b10;
                bus.sel_alu_src_b = 2'b01;
                state_n           = JALR2;
            end
            LUI: begin
                bus.sel_alu_src_a = 2'b11;
                bus.sel_alu_src_b = 2'b01;
                bus.sel_ext       = EXT_U;
                state_n           = ALUWB;
            end
            AUIPC: begin
                bus.sel_alu_src_a = 2'b01;
                bus.sel_alu_src_b = 2'b01;
                bus.sel_ext       = EXT_U;
                state_n           = ALUWB;
            end
            ILLEGAL: begin
`ifdef RV_MC_ILLEGAL_TRAP_EN
                state_n = ERROR;
`else
                state_n = FETCH;
`endif
            end
            ERROR:   state_n = ERROR;
            default: state_n = FETCH;
        endcase
    end

    // Any state change (including entering a request state) or a ready restarts the wait count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state_n != state) || bus.mem_ready) begin
            wait_cnt <= '0;
        end else if (bus.mem_req) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if ((state_n == FETCH) && (state != FETCH)) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (bus.mem_req && timeout) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign bus.instret = instret_q;
    assign bus.bus_err = bus_err_q;

`ifdef RV_MC_ILLEGAL_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else if (state == ILLEGAL) begin
            trap_q <= 1'b1;
        end
    end

    assign bus.trap = trap_q;
`else
    assign bus.trap = 1'b0;
`endif
endmodule

// File: doc/rv_mc_ctrl_hs.md
Name: rv_mc_ctrl_hs

Overview:
- Parametrised next-generation control unit for the multicycle RV32I core.
- Drives the existing datapath select/enable signals.
- Adds a req/ready handshake to the unified memory, so memory latency may vary; plain single-cycle memory ties mem_ready high.
- Adds the full RV32I branch set, a memory-wait watchdog, a retired-instruction counter and an optional illegal-opcode trap.

Parameters:
- MEM_TIMEOUT, 0: maximum wait cycles per memory access before error; 0 disables the watchdog.
- TMO_W, 8: width of the wait counter; MEM_TIMEOUT must be less than 2^TMO_W.
- CNT_W, 32: width of instret.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- sel_alu_src_a  out  2  00 PC, 01 old PC, 10 rs1, 11 zero
- sel_alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
- sel_result  out  2  00 ALUOut reg, 01 data reg, 10 ALU direct
- sel_mem_addr  out  1  0 PC, 1 result
- sel_ext  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- alu_control  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
- we_mem  out  1  memory write enable
- we_pc  out  1  PC write enable, branch qualification included
- we_ir  out  1  IR and old-PC write enable
- we_rf  out  1  register-file write enable
- bus_err  out  1  sticky watchdog error
- trap  out  1  sticky illegal-instruction flag
- instret  out  CNT_W  count of retired instructions

Behaviour:
- Reset: state=FETCH, wait counter=0, instret=0, bus_err=0, trap=0.
- All enables are 0 outside the states listed below. Select outputs are don't-care when unused but are driven to 0.
- States and actions:
  - FETCH: mem_req=1, sel_mem_addr=0, ALU = PC+4 (a=00, b=10, add), sel_result=10. When mem_ready=1: we_ir=1, we_pc=1, go to DECODE. Otherwise hold; we_ir and we_pc stay 0.
  - DECODE: ALUOut = oldPC+imm (a=01, b=01, add). sel_ext=J when op is jal, otherwise B. Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - anything else -> ILLEGAL
  - MEMADR: a=10, b=01, add, sel_ext=S for stores and I for loads. Loads go to MEMREAD, stores go to MEMWRITE.
  - MEMREAD: mem_req=1, sel_mem_addr=1, sel_result=00. Go to MEMWB on mem_ready.
  - MEMWB: sel_result=01, we_rf=1. Go to FETCH.
  - MEMWRITE: mem_req=1, we_mem=1, sel_mem_addr=1, sel_result=00. Go to FETCH on mem_ready. we_mem is held for every wait cycle.
  - EXECR: a=10, b=00. alu_control from funct3/funct7b5: funct7b5=1 selects sub for funct3=000 and sra for funct3=101. Go to ALUWB.
  - EXECI: a=10, b=01, sel_ext=I. funct7b5 is honoured only for funct3=101 (srai), never selects sub. Go to ALUWB.
  - ALUWB: sel_result=00, we_rf=1. Go to FETCH.
  - BRANCH: a=10, b=00, sub, sel_result=00. we_pc = cond, where by funct3:
    - 000 zero
    - 001 !zero
    - 100 lt
    - 101 !lt
    - 110 ltu
    - 111 !ltu
    - 010 and 011 give cond=0.
    Go to FETCH.
  - JAL: a=01, b=10, add, sel_result=00, we_pc=1. Go to ALUWB.
  - JALR: a=10, b=01, sel_ext=I, add. Go to JALR2.
  - JALR2: a=01, b=10, add, sel_result=00, we_pc=1. Go to ALUWB.
  - LUI: a=11, b=01, sel_ext=U, add. Go to ALUWB.
  - AUIPC: a=01, b=01, sel_ext=U, add. Go to ALUWB.
  - ILLEGAL: see Optional Feature.
  - ERROR: all enables and mem_req 0; the FSM stays here until rst.
- Retirement: instret increments by 1 on every transition into FETCH from any state except FETCH itself. It wraps modulo 2^CNT_W.
- Watchdog (MEM_TIMEOUT>0):
  - The wait counter clears on entering any mem_req state and on mem_ready.
  - It increments each cycle while mem_req=1 and mem_ready=0.
  - When the counter equals MEM_TIMEOUT with mem_ready=0, go to ERROR and set bus_err.
  - If mem_ready=1 in that same cycle, the access completes and no error is raised.
- rst overrides everything, including ERROR and mid-wait states; mem_req drops the cycle after rst is sampled.

Optional Feature:
- Macro: RV_MC_ILLEGAL_TRAP_EN.
- Defined: ILLEGAL sets trap=1 and enters ERROR; instret does not count the instruction.
- Undefined: ILLEGAL behaves as a NOP. It goes to FETCH with no register or memory write (PC was already advanced in FETCH), counts as retired, and trap is tied to 0.

Test Plan:
- mem_ready=1 constant, run addi x1,x0,5: FETCH->DECODE->EXECI->ALUWB->FETCH in 4 cycles; we_rf pulses once with sel_result=00; instret=1.
- lw with mem_ready held low 3 cycles in MEMREAD: mem_req held 4 cycles, state stays MEMREAD, MEMWB occurs one cycle after ready; we_rf=1 once.
- bltu with lt=1, ltu=0 -> we_pc=0 in BRANCH; repeat with ltu=1 -> we_pc=1; bge with lt=0 -> we_pc=1.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH: ERROR entered after 4 wait cycles, bus_err=1 and sticky, mem_req=0; pulse rst -> FETCH, bus_err=0, instret=0.
- op=0000000 with RV_MC_ILLEGAL_TRAP_EN defined: trap=1, ERROR state, instret unchanged. Undefined: back to FETCH after DECODE, instret+1, no we_rf/we_mem.
- sw with mem_ready low 2 cycles: we_mem and mem_req asserted 3 cycles with sel_mem_addr=1; next state FETCH.
